parity_frame_tx: RTL and testbench



---
 rtl/parity_frame_pkg.sv | 24 ++
 rtl/parity_frame_tx_bit_tick_counter.sv | 30 +++
 rtl/parity_frame_tx.sv | 130 +++++++++++++
 tb/tb_parity_frame_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and constants for the parity frame transmitter.
// Holds the FSM state encoding, the idle line level and the counter width helper.
package parity_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } frame_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    // A divide-by-one counter still needs one bit so the port stays legal.
    function automatic int cnt_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_tick_counter.sv
// Bit period timer: counts clock cycles inside one serial bit and flags the
// last cycle of each bit period with tick.
module bit_tick_counter
    import parity_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_r;

    // Cycle counter, held at zero while cleared and wrapping after the last cycle.
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign tick = (count_r == LAST_CNT);

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB first, parity bit
// accumulated while shifting, stop bit. One word per valid/ready handshake.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD          = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int IDX_W = $clog2(DATA_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic ODD_BIT = (ODD != 0) ? 1'b1 : 1'b0;

    frame_state_e      state_r, state_s;
    logic [DATA_W-1:0] shift_r, shift_s;
    logic [IDX_W-1:0]  idx_r, idx_s;
    logic              acc_r, acc_s;
    logic              tx_r, tx_s;
    logic              tick_s;
    logic              clear_s;

    assign clear_s    = (state_r == IDLE);
    assign in_ready   = (state_r == IDLE) && !rst;
    assign busy       = (state_r != IDLE);
    assign frame_done = (state_r == STOP) && tick_s;
    assign tx         = tx_r;

    bit_tick_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(clear_s),
        .tick (tick_s)
    );

    // Next-state, datapath update and the line level for the coming cycle.
    always_comb begin
        state_s = state_r;
        shift_s = shift_r;
        idx_s   = idx_r;
        acc_s   = acc_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shift_s = in_data;
                    idx_s   = '0;
                    acc_s   = 1'b0;
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (tick_s) begin
                    state_s = DATA;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (tick_s) begin
                    acc_s   = acc_r ^ shift_r[0];
                    shift_s = shift_r >> 1;
                    idx_s   = idx_r + IDX_W'(1);
                    if (idx_r == LAST_IDX) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (tick_s) begin
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (tick_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // tx is registered, so it is decoded from where the FSM is going.
        case (state_s)
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
            PARITY:  tx_s = acc_s ^ ODD_BIT;
            default: tx_s = IDLE_LEVEL;
        endcase
    end

    // State, shift register, parity accumulator and line register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            shift_r <= '0;
            idx_r   <= '0;
            acc_r   <= 1'b0;
            tx_r    <= IDLE_LEVEL;
        end else begin
            state_r <= state_s;
            shift_r <= shift_s;
            idx_r   <= idx_s;
            acc_r   <= acc_s;
            tx_r    <= tx_s;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Self-checking bench for parity_frame_tx: expected per-cycle line states are
// queued at stimulus time and compared cycle by cycle against three configurations.
module tb_parity_frame_tx;

    typedef struct packed {
        logic tx;
        logic done;
        logic busy;
        logic rdy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d0, d1;
    logic [2:0] d2;
    logic       v0, v1, v2;
    logic       r0, r1, r2;
    logic       t0, t1, t2;
    logic       b0, b1, b2;
    logic       f0, f1, f2;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(0)) dut (
        .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0),
        .tx(t0), .busy(b0), .frame_done(f0));

    parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1),
        .tx(t1), .busy(b1), .frame_done(f1));

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(1), .ODD(0)) dut_small (
        .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
        .tx(t2), .busy(b2), .frame_done(f2));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic push_frame(input logic [15:0] data, input int dw, input int cpb, input logic odd);
        int   ones;
        logic par;
        logic lvl;
        exp_t e;
        ones = 0;
        for (int i = 0; i < dw; i++) ones += int'(data[i]);
        par = (ones % 2 == 1) ^ odd;
        for (int b = 0; b < dw + 3; b++) begin
            if (b == 0) lvl = 1'b0;
            else if (b <= dw) lvl = data[b-1];
            else if (b == dw + 1) lvl = par;
            else lvl = 1'b1;
            for (int c = 0; c < cpb; c++) begin
                e.tx   = lvl;
                e.done = (b == dw + 2) && (c == cpb - 1);
                e.busy = 1'b1;
                e.rdy  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic push_idle();
        exp_t e;
        e.tx = 1'b1; e.done = 1'b0; e.busy = 1'b0; e.rdy = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int sel, output exp_t o);
        case (sel)
            0:       o = {t0, f0, b0, r0};
            1:       o = {t1, f1, b1, r1};
            default: o = {t2, f2, b2, r2};
        endcase
    endtask

    task automatic set_valid(input int sel, input logic v);
        case (sel)
            0:       v0 = v;
            1:       v1 = v;
            default: v2 = v;
        endcase
    endtask

    task automatic start_frame(input int sel, input logic [15:0] data);
        @(negedge clk);
        case (sel)
            0:       d0 = data[7:0];
            1:       d1 = data[7:0];
            default: d2 = data[2:0];
        endcase
        set_valid(sel, 1'b1);
        @(posedge clk);
        #1 set_valid(sel, 1'b0);
    endtask

    // Drains the scoreboard one cycle per entry; optionally disturbs inputs or
    // drops a held in_valid once an idle (ready) cycle has been seen.
    task automatic run_check(input int sel, input string name, input bit disturb, input bit hold_valid);
        exp_t e, o;
        int   i;
        i = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            observe(sel, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s cycle %0d: tx/done/busy/rdy got %b expected %b", name, i, o, e);
            end
            if (disturb) begin
                if (i >= 3 && i < 35) begin
                    d0 = 8'($urandom);
                    v0 = 1'($urandom_range(0, 1));
                end else begin
                    v0 = 1'b0;
                end
            end
            if (hold_valid && e.rdy) begin
                @(posedge clk);
                #1 set_valid(sel, 1'b0);
            end
            i++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; v1 = 1'b1; v2 = 1'b1;
        d0 = 8'hA5; d1 = 8'hA5; d2 = 3'b101;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({t0, f0, b0, r0} !== 4'b1000) begin
                errors++;
                $display("FAIL reset_hold: tx/done/busy/rdy got %b expected 1000", {t0, f0, b0, r0});
            end
        end
        rst = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        #1;
        checks++;
        if ({t0, f0, b0, r0} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_release: tx/done/busy/rdy got %b expected 1001", {t0, f0, b0, r0});
        end
        @(negedge clk);
        checks++;
        if ({t0, f0, b0, r0} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_no_frame: tx/done/busy/rdy got %b expected 1001", {t0, f0, b0, r0});
        end
    endtask

    task automatic test_even_frame();
        push_frame(16'h00A5, 8, 4, 1'b0);
        push_idle();
        start_frame(0, 16'h00A5);
        run_check(0, "even_a5", 1'b0, 1'b0);
    endtask

    task automatic test_parity_values();
        push_frame(16'h0007, 8, 4, 1'b0);
        push_idle();
        start_frame(0, 16'h0007);
        run_check(0, "even_07", 1'b0, 1'b0);
        push_frame(16'h0007, 8, 4, 1'b1);
        push_idle();
        start_frame(1, 16'h0007);
        run_check(1, "odd_07", 1'b0, 1'b0);
        push_frame(16'h0000, 8, 4, 1'b0);
        push_idle();
        start_frame(0, 16'h0000);
        run_check(0, "even_00", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        push_frame(16'h003C, 8, 4, 1'b0);
        push_idle();
        push_frame(16'h00FF, 8, 4, 1'b0);
        push_idle();
        @(negedge clk);
        d0 = 8'h3C;
        v0 = 1'b1;
        @(posedge clk);
        #1 d0 = 8'hFF;
        run_check(0, "b2b", 1'b0, 1'b1);
    endtask

    task automatic test_disturb();
        push_frame(16'h00A5, 8, 4, 1'b0);
        push_idle();
        start_frame(0, 16'h00A5);
        run_check(0, "disturb", 1'b1, 1'b0);
        v0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad;
        start_frame(0, 16'h00A5);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({t0, f0, b0} !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid: tx/done/busy got %b expected 100", {t0, f0, b0});
        end
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (f0 !== 1'b0 || t0 !== 1'b1 || b0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_abandon: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    task automatic test_small();
        push_frame(16'h0006, 3, 1, 1'b0);
        push_idle();
        start_frame(2, 16'h0006);
        run_check(2, "small_110", 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_even_frame();
        test_parity_values();
        test_back_to_back();
        test_disturb();
        test_reset_mid();
        test_small();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
